// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
// The master drives data and valid; the slave returns ready.
interface prog_loader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: takes a LEN/payload/CSUM frame, writes the payload to RAM,
// and releases the cpu reset only once the checksum verifies.
module prog_loader #(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    prog_loader_if.slave      io_rx,
    input  logic              i_start,
    output logic              o_mem_wren,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_cpu_rst,
    output logic              o_done,
    output logic              o_err
);
    localparam int CW = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL   = CW'(2 ** ADDR_W);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR
    } state_t;

    state_t            r_state;
    logic              r_rx_ready;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_sum;
    logic [ADDR_W-1:0] r_ptr;
    logic [TW-1:0]     r_timer;
    logic              r_wren;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic [DATA_W-1:0] w_byte;
    logic [DATA_W-1:0] w_sum_next;
    logic [CW-1:0]     w_len;
    logic              w_tmo;

    assign w_accept   = io_rx.rx_valid & r_rx_ready;
    assign w_byte     = io_rx.rx_data;
    assign w_sum_next = r_sum + w_byte;
    // A LEN of zero stands for a full-RAM image.
    assign w_len      = (w_byte == '0) ? FULL : CW'(w_byte);
    assign w_tmo      = (r_timer == T_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_LEN;
            r_rx_ready <= 1'b1;
            r_count    <= '0;
            r_sum      <= '0;
            r_ptr      <= BASE_ADDR;
            r_timer    <= '0;
            r_wren     <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_data     <= '0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            unique case (r_state)
                S_LEN: begin
                    if (w_accept) begin
                        r_count <= w_len;
                        r_sum   <= '0;
                        r_ptr   <= BASE_ADDR;
                        r_timer <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_wren  <= 1'b1;
                        r_addr  <= r_ptr;
                        r_data  <= w_byte;
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_sum   <= w_sum_next;
                        r_count <= r_count - CW'(1);
                        r_timer <= '0;
                        if (r_count == CW'(1)) begin
                            r_state <= S_CSUM;
                        end
                    end else if (w_tmo) begin
                        r_state    <= S_ERR;
                        r_rx_ready <= 1'b0;
                        r_err      <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        r_timer    <= '0;
                        r_rx_ready <= 1'b0;
                        if (w_sum_next == '0) begin
                            r_state   <= S_RUN;
                            r_cpu_rst <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_state    <= S_ERR;
                        r_rx_ready <= 1'b0;
                        r_err      <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RUN: begin
                    if (i_start) begin
                        r_state    <= S_LEN;
                        r_rx_ready <= 1'b1;
                        r_cpu_rst  <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (i_start) begin
                        r_state    <= S_LEN;
                        r_rx_ready <= 1'b1;
                        r_err      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_LEN;
                end
            endcase
        end
    end

    assign io_rx.rx_ready = r_rx_ready;
    assign o_mem_wren     = r_wren;
    assign o_mem_addr     = r_addr;
    assign o_mem_data     = r_data;
    assign o_cpu_rst      = r_cpu_rst;
    assign o_done         = r_done;
    assign o_err          = r_err;
endmodule
